everloop_monitor: RTL and testbench

- One-wire LED stream receiver. It decodes the NRZ pulse-width serial data that the LED ring driver emits (WS2812 timing), assembles bytes MSB first and stores each frame in a capture RAM.
- The J1 CPU reads the RAM and status registers through the 8-bit IO window.
- Used for loopback self-test of the LED chain and for monitoring the chain's DOUT.

---
 rtl/everloop_pkg.sv | 33 +++
 rtl/everloop_monitor_if.sv | 16 +
 rtl/everloop_capture_ram.sv | 42 ++++
 rtl/everloop_monitor.sv | 182 ++++++++++++++++++
 tb/tb_everloop_monitor.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/everloop_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : everloop_pkg
//  Description : Shared timing defaults, IO window map and FSM encoding for
//                the LED stream monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package everloop_pkg;

    localparam int DEPTH_DEF      = 140;
    localparam int BIT_THRESH_DEF = 30;
    localparam int MIN_HIGH_DEF   = 8;
    localparam int RESET_CYC_DEF  = 2500;
    localparam int CNT_W_DEF      = 12;

    localparam logic [7:0] ADDR_STATUS = 8'hFE;
    localparam logic [7:0] ADDR_LEN    = 8'hFF;

    localparam int STAT_GLITCH   = 0;
    localparam int STAT_PARTIAL  = 1;
    localparam int STAT_OVERFLOW = 2;
    localparam int STAT_VALID    = 3;

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_IDLE = 3'd1,
        ST_HIGH = 3'd2,
        ST_LOW  = 3'd3,
        ST_END  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/everloop_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : everloop_monitor_if
//  Description : CPU IO window of the LED stream monitor (read-only).
//  Revision    : 1.0 - initial release
// ============================================================================
interface everloop_monitor_if;
    logic       cs;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] d_out;

    modport master (output cs, output rd, output addr, input d_out);
    modport slave  (input cs, input rd, input addr, output d_out);
endinterface
`default_nettype wire

// File: rtl/everloop_capture_ram.sv
`default_nettype none
// ============================================================================
//  Module      : everloop_capture_ram
//  Description : DEPTH x 8 simple dual-port RAM, registered read-first port.
//  Revision    : 1.0 - initial release
// ============================================================================
module everloop_capture_ram #(
    parameter int DEPTH = 140,
    parameter int AW    = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [7:0]    wdata,
    input  wire logic          re,
    input  wire logic [AW-1:0] raddr,
    output logic [7:0]         rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    // Contents survive reset; only the output register clears.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 8'h00;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/everloop_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : everloop_monitor
//  Description : WS2812-style one-wire receiver capturing frames for J1 reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module everloop_monitor
    import everloop_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int BIT_THRESH = BIT_THRESH_DEF,
    parameter int MIN_HIGH   = MIN_HIGH_DEF,
    parameter int RESET_CYC  = RESET_CYC_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         led_in,
    everloop_monitor_if.slave bus,
    output logic              frame_done,
    output logic              busy
);

    localparam logic [CNT_W-1:0] C_HI_MAX    = '1;
    localparam logic [CNT_W-1:0] C_MIN_HIGH  = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] C_THRESH    = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] C_RESET_END = CNT_W'(RESET_CYC - 1);
    localparam logic [7:0]       C_DEPTH     = 8'(DEPTH);

    logic             r_sync1, r_sync2, r_line_q;
    state_t           r_state;
    logic [CNT_W-1:0] r_hi_cnt, r_lo_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift, r_wr_ptr, r_last_len, r_reg_data;
    logic             r_glitch, r_partial, r_overflow, r_valid, r_sel_ram;

    logic       w_rise, w_fall, w_pulse_ok, w_bit, w_take_bit, w_byte_done;
    logic       w_ram_we, w_rd, w_rd_ram;
    logic [7:0] w_shift_next, w_ram_waddr, w_ram_q, w_status;

    assign w_rise       = r_sync2 & ~r_line_q;
    assign w_fall       = ~r_sync2 & r_line_q;
    assign w_pulse_ok   = (r_hi_cnt >= C_MIN_HIGH);
    assign w_bit        = (r_hi_cnt >= C_THRESH);
    assign w_shift_next = {r_shift[6:0], w_bit};
    assign w_take_bit   = (r_state == ST_HIGH) && w_fall && w_pulse_ok;
    assign w_byte_done  = w_take_bit && (r_bit_cnt == 3'd7);
    assign w_ram_we     = w_byte_done && (r_wr_ptr < C_DEPTH);
    assign w_ram_waddr  = r_wr_ptr;
    assign w_rd         = bus.cs & bus.rd;
    assign w_rd_ram     = w_rd && (bus.addr < C_DEPTH);
    assign w_status     = {4'b0000, r_valid, r_overflow, r_partial, r_glitch};
    assign bus.d_out    = r_sel_ram ? w_ram_q : r_reg_data;

    everloop_capture_ram #(
        .DEPTH (DEPTH),
        .AW    (8)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (w_ram_we),
        .waddr (w_ram_waddr),
        .wdata (w_shift_next),
        .re    (w_rd_ram),
        .raddr (bus.addr),
        .rdata (w_ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_line_q   <= 1'b0;
            r_state    <= ST_SYNC;
            r_hi_cnt   <= '0;
            r_lo_cnt   <= '0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_wr_ptr   <= 8'h00;
            r_last_len <= 8'h00;
            r_reg_data <= 8'h00;
            r_sel_ram  <= 1'b0;
            r_glitch   <= 1'b0;
            r_partial  <= 1'b0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_sync1    <= led_in;
            r_sync2    <= r_sync1;
            r_line_q   <= r_sync2;
            frame_done <= 1'b0;

            // Read-side clears come first so that flag sets below win.
            if (w_rd) begin
                r_sel_ram <= w_rd_ram;
                if (bus.addr == ADDR_STATUS) begin
                    r_reg_data <= w_status;
                    r_glitch   <= 1'b0;
                    r_partial  <= 1'b0;
                    r_overflow <= 1'b0;
                end else if (bus.addr == ADDR_LEN) begin
                    r_reg_data <= r_last_len;
                    r_valid    <= 1'b0;
                end else begin
                    r_reg_data <= 8'h00;
                end
            end

            case (r_state)
                ST_SYNC: begin
                    if (r_sync2) begin
                        r_lo_cnt <= '0;
                    end else if (r_lo_cnt == C_RESET_END) begin
                        r_lo_cnt <= '0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_lo_cnt <= r_lo_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (w_rise) begin
                        r_hi_cnt <= '0;
                        busy     <= 1'b1;
                        r_state  <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (w_fall) begin
                        if (!w_pulse_ok) begin
                            r_glitch <= 1'b1;
                        end else begin
                            r_shift <= w_shift_next;
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt <= 3'd0;
                                if (r_wr_ptr < C_DEPTH) begin
                                    r_wr_ptr <= r_wr_ptr + 8'd1;
                                end else begin
                                    r_overflow <= 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                        r_lo_cnt <= '0;
                        r_state  <= ST_LOW;
                    end else if (r_hi_cnt != C_HI_MAX) begin
                        r_hi_cnt <= r_hi_cnt + 1'b1;
                    end
                end
                ST_LOW: begin
                    if (w_rise) begin
                        r_hi_cnt <= '0;
                        r_state  <= ST_HIGH;
                    end else if (r_lo_cnt == C_RESET_END) begin
                        r_state <= ST_END;
                    end else begin
                        r_lo_cnt <= r_lo_cnt + 1'b1;
                    end
                end
                ST_END: begin
                    if (r_bit_cnt != 3'd0) begin
                        r_partial <= 1'b1;
                    end
                    r_last_len <= r_wr_ptr;
                    r_valid    <= 1'b1;
                    frame_done <= 1'b1;
                    r_wr_ptr   <= 8'h00;
                    r_bit_cnt  <= 3'd0;
                    busy       <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_SYNC;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_everloop_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_everloop_monitor
//  Description : Directed bench for the LED stream monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_everloop_monitor;
    import everloop_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic led_in = 1'b0;
    logic frame_done, busy;

    int total = 0;
    int bad = 0;
    int fd_cnt = 0;
    logic found;
    logic [7:0] rdat;

    everloop_monitor_if bus ();

    everloop_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .led_in     (led_in),
        .bus        (bus),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b);
        led_in = 1'b1;
        tick(b ? 40 : 20);
        led_in = 1'b0;
        tick(b ? 22 : 42);
    endtask

    // '1' bit whose low time contains a 4-clk runt pulse
    task automatic send_one_glitch();
        led_in = 1'b1; tick(40);
        led_in = 1'b0; tick(10);
        led_in = 1'b1; tick(4);
        led_in = 1'b0; tick(8);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = a;
        @(negedge clk);
        bus.cs = 1'b0; bus.rd = 1'b0;
        d = bus.d_out;
    endtask

    task automatic end_frame(input int exp_cnt);
        led_in = 1'b0;
        for (int i = 0; i < 3000 && fd_cnt != exp_cnt; i++) @(negedge clk);
        tick(4);
        @(negedge clk);
        check("frame_done_count", fd_cnt, exp_cnt);
        check("busy_after_end", busy, 1'b0);
    endtask

    initial begin
        bus.cs = 1'b0; bus.rd = 1'b0; bus.addr = 8'h00;
        tick(5);
        @(negedge clk);
        check("rst_d_out", bus.d_out, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        rst = 1'b0;
        tick(2600);

        // basic three-byte frame
        send_byte(8'hFF);
        @(negedge clk);
        check("busy_in_frame", busy, 1'b1);
        send_byte(8'h00);
        send_byte(8'hA5);
        end_frame(1);
        cpu_read(ADDR_STATUS, rdat); check("f1_status", rdat, 8'h08);
        cpu_read(ADDR_LEN, rdat);    check("f1_len", rdat, 8'd3);
        cpu_read(ADDR_STATUS, rdat); check("f1_status_after_len", rdat, 8'h00);
        cpu_read(8'd0, rdat);        check("f1_ram0", rdat, 8'hFF);
        cpu_read(8'd1, rdat);        check("f1_ram1", rdat, 8'h00);
        cpu_read(8'd2, rdat);        check("f1_ram2", rdat, 8'hA5);
        cpu_read(8'h90, rdat);       check("unmapped_addr", rdat, 8'h00);

        // overflow: 142 bytes into a 140-byte RAM
        for (int i = 0; i < 142; i++) send_byte(8'(i * 3 + 7));
        end_frame(2);
        cpu_read(ADDR_STATUS, rdat); check("ovf_status", rdat, 8'h0C);
        cpu_read(ADDR_STATUS, rdat); check("ovf_status_cleared", rdat, 8'h08);
        cpu_read(ADDR_LEN, rdat);    check("ovf_len", rdat, 8'd140);
        cpu_read(8'd0, rdat);        check("ovf_ram0", rdat, 8'h07);
        cpu_read(8'd139, rdat);      check("ovf_ram139", rdat, 8'hA8);

        // partial: 12 bits
        send_byte(8'h3C);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        end_frame(3);
        cpu_read(ADDR_STATUS, rdat); check("part_status", rdat, 8'h0A);
        cpu_read(ADDR_LEN, rdat);    check("part_len", rdat, 8'd1);
        cpu_read(8'd0, rdat);        check("part_ram0", rdat, 8'h3C);

        // runt pulse inside byte 0x96 (1001_0110)
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_one_glitch();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        end_frame(4);
        cpu_read(ADDR_STATUS, rdat); check("glitch_status", rdat, 8'h09);
        cpu_read(ADDR_LEN, rdat);    check("glitch_len", rdat, 8'd1);
        cpu_read(8'd0, rdat);        check("glitch_ram0", rdat, 8'h96);

        // read-first collision on RAM[2] (old byte 0x0D from overflow frame)
        found = 1'b0;
        rdat  = 8'h00;
        fork
            begin
                send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
            end
            begin
                for (int i = 0; i < 4000 && !found; i++) begin
                    @(negedge clk);
                    if (dut.w_ram_we && dut.w_ram_waddr == 8'd2) begin
                        found = 1'b1;
                        bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = 8'd2;
                        @(negedge clk);
                        bus.cs = 1'b0; bus.rd = 1'b0;
                        rdat = bus.d_out;
                    end
                end
            end
        join
        check("collide_seen", found, 1'b1);
        check("collide_old", rdat, 8'h0D);
        cpu_read(8'd2, rdat);        check("collide_new", rdat, 8'h33);
        end_frame(5);
        cpu_read(ADDR_LEN, rdat);    check("collide_len", rdat, 8'd3);

        // reset in the middle of byte 5
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        led_in = 1'b1;
        tick(15);
        @(negedge clk);
        check("busy_before_rst", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_d_out", bus.d_out, 8'h00);
        tick(20);
        led_in = 1'b0;
        tick(100);
        send_byte(8'hEE);
        tick(2600);
        @(negedge clk);
        check("sync_ignores_frame", fd_cnt, 5);
        send_byte(8'h5A);
        end_frame(6);
        cpu_read(ADDR_STATUS, rdat); check("post_rst_status", rdat, 8'h08);
        cpu_read(ADDR_LEN, rdat);    check("post_rst_len", rdat, 8'd1);
        cpu_read(8'd0, rdat);        check("post_rst_ram0", rdat, 8'h5A);
        cpu_read(8'd1, rdat);        check("post_rst_ram1_kept", rdat, 8'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
